wb_arb2: RTL and testbench

WB_ARB2 -- requirements
Module: wb_arb2

---
 rtl/wb_arb_pkg.sv | 17 +
 rtl/wb_tag_fifo.sv | 75 +++++++
 rtl/wb_arb2.sv | 162 ++++++++++++++++
 tb/tb_wb_arb2.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// +--------------------------------------------------------------+
// | wb_arb_pkg : shared port-id type and tag-queue sizing        |
// | Revision   : 1.0                                             |
// +--------------------------------------------------------------+
`default_nettype none

package wb_arb_pkg;

  typedef logic port_id_t;

  localparam port_id_t    PORT_IFETCH = 1'b0;
  localparam port_id_t    PORT_DMEM   = 1'b1;
  localparam int unsigned TAG_DEPTH   = 2;

endpackage

`default_nettype wire

// File: rtl/wb_tag_fifo.sv
// +--------------------------------------------------------------+
// | wb_tag_fifo : in-order queue of port ids awaiting a response |
// | Revision    : 1.0                                            |
// +--------------------------------------------------------------+
`default_nettype none

module wb_tag_fifo
  import wb_arb_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     push_i,
  input  port_id_t push_data_i,
  input  logic     pop_i,
  output logic     accept_o,
  output logic     valid_o,
  output port_id_t data_o
);

  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = $clog2(TAG_DEPTH + 1);

  port_id_t         mem_q [TAG_DEPTH];
  port_id_t         mem_d [TAG_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Accept is taken from the registered count, so a pop never frees space for a same-cycle push.
  assign accept_o = (count_q != CNT_W'(TAG_DEPTH));
  assign valid_o  = (count_q != '0);
  assign data_o   = mem_q[rd_ptr_q];
  assign do_push  = push_i & accept_o;
  assign do_pop   = pop_i & valid_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < TAG_DEPTH; i++) begin
        mem_q[i] <= PORT_IFETCH;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_arb2.sv
// +--------------------------------------------------------------+
// | wb_arb2  : two-port to pipelined Wishbone master arbiter     |
// |            option WB_ARB2_FIXED_PRIO_EN: port 1 wins ties    |
// | Revision : 1.0                                               |
// +--------------------------------------------------------------+
`default_nettype none

module wb_arb2
  import wb_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                p0_req_i,
  input  logic                p0_we_i,
  input  logic [ADDR_W-1:0]   p0_addr_i,
  input  logic [DATA_W-1:0]   p0_wdata_i,
  input  logic [DATA_W/8-1:0] p0_sel_i,
  output logic                p0_accept_o,
  output logic                p0_ack_o,
  output logic                p0_err_o,
  output logic [DATA_W-1:0]   p0_rdata_o,
  input  logic                p1_req_i,
  input  logic                p1_we_i,
  input  logic [ADDR_W-1:0]   p1_addr_i,
  input  logic [DATA_W-1:0]   p1_wdata_i,
  input  logic [DATA_W/8-1:0] p1_sel_i,
  output logic                p1_accept_o,
  output logic                p1_ack_o,
  output logic                p1_err_o,
  output logic [DATA_W-1:0]   p1_rdata_o,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [ADDR_W-1:0]   wb_adr_o,
  output logic [DATA_W-1:0]   wb_dat_o,
  output logic [DATA_W/8-1:0] wb_sel_o,
  input  logic                wb_stall_i,
  input  logic                wb_ack_i,
  input  logic                wb_err_i,
  input  logic [DATA_W-1:0]   wb_dat_i
);

  localparam int SEL_W = DATA_W / 8;

  logic              stb_q, stb_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
`ifndef WB_ARB2_FIXED_PRIO_EN
  port_id_t          last_grant_q, last_grant_d;
`endif

  port_id_t grant;
  port_id_t tag_head;
  logic     stage_free;
  logic     load;
  logic     tag_accept;
  logic     tag_valid;
  logic     rsp_valid;

  always_comb begin
    grant = PORT_IFETCH;
    if (p0_req_i && p1_req_i) begin
`ifdef WB_ARB2_FIXED_PRIO_EN
      grant = PORT_DMEM;
`else
      grant = ~last_grant_q;
`endif
    end else if (p1_req_i) begin
      grant = PORT_DMEM;
    end
  end

  assign stage_free = ~stb_q | ~wb_stall_i;
  // Gated by rst_i so no request is taken while reset is held.
  assign load       = ~rst_i & stage_free & tag_accept & (p0_req_i | p1_req_i);
  assign rsp_valid  = (wb_ack_i | wb_err_i) & tag_valid;

  assign p0_accept_o = load & (grant == PORT_IFETCH);
  assign p1_accept_o = load & (grant == PORT_DMEM);
  assign p0_ack_o    = rsp_valid & ~wb_err_i & (tag_head == PORT_IFETCH);
  assign p1_ack_o    = rsp_valid & ~wb_err_i & (tag_head == PORT_DMEM);
  assign p0_err_o    = rsp_valid & wb_err_i & (tag_head == PORT_IFETCH);
  assign p1_err_o    = rsp_valid & wb_err_i & (tag_head == PORT_DMEM);
  assign p0_rdata_o  = wb_dat_i;
  assign p1_rdata_o  = wb_dat_i;

  assign wb_cyc_o = stb_q | tag_valid;
  assign wb_stb_o = stb_q;
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_sel_o = sel_q;

  always_comb begin
    stb_d = stb_q;
    we_d  = we_q;
    adr_d = adr_q;
    dat_d = dat_q;
    sel_d = sel_q;
    if (load) begin
      stb_d = 1'b1;
      if (grant == PORT_DMEM) begin
        we_d  = p1_we_i;
        adr_d = p1_addr_i;
        dat_d = p1_wdata_i;
        sel_d = p1_sel_i;
      end else begin
        we_d  = p0_we_i;
        adr_d = p0_addr_i;
        dat_d = p0_wdata_i;
        sel_d = p0_sel_i;
      end
    end else if (stage_free) begin
      stb_d = 1'b0;
    end
  end

`ifndef WB_ARB2_FIXED_PRIO_EN
  assign last_grant_d = load ? grant : last_grant_q;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
`ifndef WB_ARB2_FIXED_PRIO_EN
      last_grant_q <= PORT_DMEM;
`endif
    end else begin
      stb_q        <= stb_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      sel_q        <= sel_d;
`ifndef WB_ARB2_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  wb_tag_fifo u_tag_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (load),
    .push_data_i (grant),
    .pop_i       (rsp_valid),
    .accept_o    (tag_accept),
    .valid_o     (tag_valid),
    .data_o      (tag_head)
  );

endmodule

`default_nettype wire

// File: tb/tb_wb_arb2.sv
// +--------------------------------------------------------------+
// | tb_wb_arb2 : directed + random bench with a queue-based model|
// | Revision   : 1.0                                             |
// +--------------------------------------------------------------+
`default_nettype none

module tb_wb_arb2;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SEL_W  = DATA_W / 8;

`ifdef WB_ARB2_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              p0_req_i, p0_we_i, p1_req_i, p1_we_i;
  logic [ADDR_W-1:0] p0_addr_i, p1_addr_i;
  logic [DATA_W-1:0] p0_wdata_i, p1_wdata_i;
  logic [SEL_W-1:0]  p0_sel_i, p1_sel_i;
  logic              p0_accept_o, p0_ack_o, p0_err_o;
  logic              p1_accept_o, p1_ack_o, p1_err_o;
  logic [DATA_W-1:0] p0_rdata_o, p1_rdata_o;
  logic              wb_cyc_o, wb_stb_o, wb_we_o;
  logic [ADDR_W-1:0] wb_adr_o;
  logic [DATA_W-1:0] wb_dat_o;
  logic [SEL_W-1:0]  wb_sel_o;
  logic              wb_stall_i, wb_ack_i, wb_err_i;
  logic [DATA_W-1:0] wb_dat_i;

  always #5 clk_i = ~clk_i;

  wb_arb2 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .p0_req_i(p0_req_i), .p0_we_i(p0_we_i), .p0_addr_i(p0_addr_i),
    .p0_wdata_i(p0_wdata_i), .p0_sel_i(p0_sel_i),
    .p0_accept_o(p0_accept_o), .p0_ack_o(p0_ack_o), .p0_err_o(p0_err_o),
    .p0_rdata_o(p0_rdata_o),
    .p1_req_i(p1_req_i), .p1_we_i(p1_we_i), .p1_addr_i(p1_addr_i),
    .p1_wdata_i(p1_wdata_i), .p1_sel_i(p1_sel_i),
    .p1_accept_o(p1_accept_o), .p1_ack_o(p1_ack_o), .p1_err_o(p1_err_o),
    .p1_rdata_o(p1_rdata_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_stall_i(wb_stall_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_dat_i(wb_dat_i)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: pending strobe plus an ordered list of owners of unanswered requests.
  bit                m_stb;
  bit                m_we;
  logic [ADDR_W-1:0] m_adr;
  logic [DATA_W-1:0] m_dat;
  logic [SEL_W-1:0]  m_sel;
  bit                m_last;
  bit                m_owner[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_stb  = 1'b0;
    m_last = 1'b1;
    m_owner.delete();
  endtask

  // Called at a falling edge with inputs already applied; checks, advances the model, waits one cycle.
  task automatic step();
    bit free, winner, take, rsp, head;
    #1;
    free   = !m_stb || !wb_stall_i;
    take   = free && (m_owner.size() < 2) && (p0_req_i || p1_req_i);
    if (p0_req_i && p1_req_i) winner = FIXED_PRIO ? 1'b1 : !m_last;
    else                      winner = p1_req_i;
    rsp    = (wb_ack_i || wb_err_i) && (m_owner.size() > 0);
    head   = (m_owner.size() > 0) ? m_owner[0] : 1'b0;

    chk("p0_accept", p0_accept_o, take && !winner);
    chk("p1_accept", p1_accept_o, take && winner);
    chk("p0_ack", p0_ack_o, rsp && !wb_err_i && !head);
    chk("p1_ack", p1_ack_o, rsp && !wb_err_i && head);
    chk("p0_err", p0_err_o, rsp && wb_err_i && !head);
    chk("p1_err", p1_err_o, rsp && wb_err_i && head);
    chk("p0_rdata", p0_rdata_o, wb_dat_i);
    chk("p1_rdata", p1_rdata_o, wb_dat_i);
    chk("wb_stb", wb_stb_o, m_stb);
    chk("wb_cyc", wb_cyc_o, m_stb || (m_owner.size() > 0));
    if (m_stb) begin
      chk("wb_we", wb_we_o, m_we);
      chk("wb_adr", wb_adr_o, m_adr);
      chk("wb_dat", wb_dat_o, m_dat);
      chk("wb_sel", wb_sel_o, m_sel);
    end

    if (rsp) void'(m_owner.pop_front());
    if (take) begin
      m_owner.push_back(winner);
      m_last = winner;
      m_stb  = 1'b1;
      m_we   = winner ? p1_we_i    : p0_we_i;
      m_adr  = winner ? p1_addr_i  : p0_addr_i;
      m_dat  = winner ? p1_wdata_i : p0_wdata_i;
      m_sel  = winner ? p1_sel_i   : p0_sel_i;
    end else if (free) begin
      m_stb = 1'b0;
    end
    @(negedge clk_i);
  endtask

  task automatic drive(input bit r0, input bit r1, input bit stall, input bit ack,
                       input bit err, input logic [DATA_W-1:0] dat);
    p0_req_i   = r0;
    p1_req_i   = r1;
    wb_stall_i = stall;
    wb_ack_i   = ack;
    wb_err_i   = err;
    wb_dat_i   = dat;
    step();
  endtask

  initial begin
    rst_i = 1'b1;
    p0_req_i = 0; p1_req_i = 0; p0_we_i = 0; p1_we_i = 0;
    p0_addr_i = '0; p1_addr_i = '0; p0_wdata_i = '0; p1_wdata_i = '0;
    p0_sel_i = '0; p1_sel_i = '0;
    wb_stall_i = 0; wb_ack_i = 0; wb_err_i = 0; wb_dat_i = '0;
    model_reset();

    // Reset state, with both ports already requesting.
    repeat (2) @(negedge clk_i);
    p0_req_i = 1; p1_req_i = 1;
    #1;
    chk("rst_stb", wb_stb_o, 1'b0);
    chk("rst_cyc", wb_cyc_o, 1'b0);
    chk("rst_we", wb_we_o, 1'b0);
    chk("rst_adr", wb_adr_o, 32'h0);
    chk("rst_dat", wb_dat_o, 32'h0);
    chk("rst_sel", wb_sel_o, 4'h0);
    chk("rst_accept", {p0_accept_o, p1_accept_o}, 2'b00);
    chk("rst_resp", {p0_ack_o, p1_ack_o, p0_err_o, p1_err_o}, 4'h0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Tie from reset with an ack every cycle.
    p0_addr_i = 32'h1000; p1_addr_i = 32'h2000; p0_sel_i = 4'hF; p1_sel_i = 4'hF;
    for (int i = 0; i < 8; i++) drive(1, 1, 0, 1, 0, 32'h100 + i);
    drive(0, 0, 0, 1, 0, 32'h0);
    drive(0, 0, 0, 1, 0, 32'h0);
    drive(0, 0, 0, 0, 0, 32'h0);

    // Single read from port 0, acked two cycles after acceptance.
    p0_we_i = 0; p0_addr_i = 32'h100; p0_sel_i = 4'hF;
    drive(1, 0, 0, 0, 0, 32'h0);
    drive(0, 0, 0, 0, 0, 32'h0);
    drive(0, 0, 0, 1, 0, 32'hDEADBEEF);
    drive(0, 0, 0, 0, 0, 32'h0);

    // Port 1 write held under a five-cycle stall.
    p1_we_i = 1; p1_addr_i = 32'h200; p1_wdata_i = 32'h55AA; p1_sel_i = 4'h3;
    drive(0, 1, 0, 0, 0, 32'h0);
    p1_addr_i = 32'h204; p1_wdata_i = 32'h1234;
    for (int i = 0; i < 5; i++) drive(0, 1, 1, 0, 0, 32'h0);
    drive(0, 0, 0, 0, 0, 32'h0);
    drive(0, 0, 0, 1, 0, 32'h0);
    drive(0, 0, 0, 1, 0, 32'h0);
    drive(0, 0, 0, 0, 0, 32'h0);

    // Backpressure: no acks, then a single ack frees one slot.
    p0_we_i = 0; p1_we_i = 0;
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 0, 0, 32'h0);
    drive(1, 1, 0, 1, 0, 32'hCAFE0001);
    for (int i = 0; i < 2; i++) drive(1, 1, 0, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0, 32'hCAFE0002);

    // Error on port 1, then a spurious ack and a combined ack+err with nothing outstanding.
    drive(0, 1, 0, 0, 0, 32'h0);
    drive(0, 0, 0, 0, 0, 32'h0);
    drive(0, 0, 0, 0, 1, 32'hBAD0BAD0);
    drive(0, 0, 0, 1, 0, 32'h12345678);
    drive(0, 0, 0, 1, 1, 32'h0);

    // Reset with two requests outstanding; later acks are spurious.
    drive(1, 1, 0, 0, 0, 32'h0);
    drive(1, 1, 0, 0, 0, 32'h0);
    p0_req_i = 0; p1_req_i = 0;
    #2 rst_i = 1'b1;
    #1;
    chk("midrst_cyc", wb_cyc_o, 1'b0);
    chk("midrst_stb", wb_stb_o, 1'b0);
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    drive(0, 0, 0, 1, 0, 32'h0);
    drive(0, 0, 0, 1, 0, 32'h0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      p0_we_i    = $urandom_range(0, 1);
      p1_we_i    = $urandom_range(0, 1);
      p0_addr_i  = $urandom;
      p1_addr_i  = $urandom;
      p0_wdata_i = $urandom;
      p1_wdata_i = $urandom;
      p0_sel_i   = SEL_W'($urandom);
      p1_sel_i   = SEL_W'($urandom);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 9) == 0, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
